// File: rtl/lsu.sv
// rtl/lsu.sv - load/store unit: one memory access at a time over a req/gnt/rvalid bus
// Lane steering, write strobes, load extension, misalign/illegal detection and response timeout.
module lsu #(
  parameter int CPU_WIDTH = 32,
  parameter int TIMEOUT   = 255
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_lsu_valid,
  output logic                 o_lsu_ready,
  input  logic                 i_lsu_wen,
  input  logic [2:0]           i_lsu_op,
  input  logic [CPU_WIDTH-1:0] i_exu_rd_data,
  input  logic [CPU_WIDTH-1:0] i_idu_rs2_data,
  output logic                 o_mem_req,
  input  logic                 i_mem_gnt,
  output logic                 o_mem_we,
  output logic [CPU_WIDTH-1:0] o_mem_addr,
  output logic [CPU_WIDTH-1:0] o_mem_wdata,
  output logic [3:0]           o_mem_wstrb,
  input  logic                 i_mem_rvalid,
  input  logic [CPU_WIDTH-1:0] i_mem_rdata,
  output logic                 o_lsu_done,
  output logic [CPU_WIDTH-1:0] o_lsu_rdata,
  output logic                 o_lsu_err,
  output logic [1:0]           o_lsu_err_cause
);

  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [2:0]      op_q;
  logic [1:0]      off_q;
  logic            we_q;
  logic [31:0]     addr_q, wdata_q, rdata_q;
  logic [3:0]      wstrb_q;
  logic            err_q;
  logic [1:0]      cause_q;

  logic            illegal, misaligned, timeout_hit;
  logic [31:0]     wdata_steer;
  logic [3:0]      wstrb_steer;
  logic [7:0]      lane_byte;
  logic [15:0]     lane_half;
  logic [31:0]     load_ext;

  // Decode of the op being offered; only used on the accept cycle.
  always_comb begin
    illegal    = (i_lsu_op == 3'b011) || (i_lsu_op == 3'b110) || (i_lsu_op == 3'b111) ||
                 (i_lsu_wen && i_lsu_op[2]);
    misaligned = ((i_lsu_op[1:0] == 2'b01) && i_exu_rd_data[0]) ||
                 ((i_lsu_op[1:0] == 2'b10) && (i_exu_rd_data[1:0] != 2'b00));
  end

  always_comb begin
    wdata_steer = i_idu_rs2_data;
    wstrb_steer = 4'b1111;
    case (i_lsu_op[1:0])
      2'b00: begin
        wdata_steer = {4{i_idu_rs2_data[7:0]}};
        wstrb_steer = 4'b0001 << i_exu_rd_data[1:0];
      end
      2'b01: begin
        wdata_steer = {2{i_idu_rs2_data[15:0]}};
        wstrb_steer = 4'b0011 << i_exu_rd_data[1:0];
      end
      default: ;
    endcase
    if (!i_lsu_wen) wstrb_steer = 4'b0000;
  end

  always_comb begin
    lane_byte = i_mem_rdata[{off_q, 3'b000} +: 8];
    lane_half = i_mem_rdata[{off_q[1], 4'b0000} +: 16];
    case (op_q)
      3'b000:  load_ext = {{24{lane_byte[7]}}, lane_byte};
      3'b001:  load_ext = {{16{lane_half[15]}}, lane_half};
      3'b100:  load_ext = {24'h000000, lane_byte};
      3'b101:  load_ext = {16'h0000, lane_half};
      default: load_ext = i_mem_rdata;
    endcase
  end

  assign timeout_hit = (cnt == CW'(TIMEOUT - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (i_lsu_valid) state_nxt = (illegal || misaligned) ? S_DONE : S_REQ;
      S_REQ:  if (i_mem_gnt) state_nxt = S_WAIT;
              else if (timeout_hit) state_nxt = S_DONE;
      S_WAIT: if (i_mem_rvalid || timeout_hit) state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      op_q    <= 3'b000;
      off_q   <= 2'b00;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= 4'b0000;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cause_q <= CAUSE_NONE;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: if (i_lsu_valid) begin
          op_q    <= i_lsu_op;
          off_q   <= i_exu_rd_data[1:0];
          we_q    <= i_lsu_wen;
          addr_q  <= {i_exu_rd_data[31:2], 2'b00};
          wdata_q <= wdata_steer;
          wstrb_q <= wstrb_steer;
          cnt     <= '0;
          rdata_q <= '0;
          err_q   <= illegal || misaligned;
          cause_q <= illegal ? CAUSE_ILLEGAL : (misaligned ? CAUSE_MISALIGN : CAUSE_NONE);
        end
        S_REQ: begin
          cnt <= cnt + CW'(1);
          if (!i_mem_gnt && timeout_hit) begin
            err_q   <= 1'b1;
            cause_q <= CAUSE_TIMEOUT;
          end
        end
        S_WAIT: begin
          cnt <= cnt + CW'(1);
          // A response on the limit cycle still completes the access.
          if (i_mem_rvalid) begin
            rdata_q <= we_q ? 32'h0 : load_ext;
          end else if (timeout_hit) begin
            err_q   <= 1'b1;
            cause_q <= CAUSE_TIMEOUT;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_lsu_ready     = (state == S_IDLE);
  assign o_mem_req       = (state == S_REQ);
  assign o_mem_we        = we_q;
  assign o_mem_addr      = addr_q;
  assign o_mem_wdata     = wdata_q;
  assign o_mem_wstrb     = wstrb_q;
  assign o_lsu_done      = (state == S_DONE);
  assign o_lsu_rdata     = rdata_q;
  assign o_lsu_err       = err_q;
  assign o_lsu_err_cause = cause_q;

endmodule
